// File: rtl/alu_regfile.sv
// alu_regfile: small register file with a multi-cycle ALU front end.
// One request is accepted at a time. Single-cycle ops finish on the edge
// after acceptance. MUL is an iterative shift-add that finishes WIDTH
// edges after acceptance. res_valid pulses for one cycle on completion.
module alu_regfile #(
    parameter int WIDTH = 8,
    parameter int NREG  = 4,
    localparam int AW   = $clog2(NREG)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [3:0]       opcode,
    input  logic [AW-1:0]    src_a,
    input  logic [AW-1:0]    src_b,
    input  logic [AW-1:0]    dst,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] Y,
    output logic [3:0]       flags,
    output logic             res_valid,
    input  logic [AW-1:0]    dbg_sel,
    output logic [WIDTH-1:0] dbg_data
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_SHL  = 4'h2;
    localparam logic [3:0] OP_SHR  = 4'h3;
    localparam logic [3:0] OP_CMP  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_NAND = 4'h8;
    localparam logic [3:0] OP_NOR  = 4'h9;
    localparam logic [3:0] OP_XNOR = 4'hA;
    localparam logic [3:0] OP_NOT  = 4'hB;
    localparam logic [3:0] OP_NEG  = 4'hC;
    localparam logic [3:0] OP_MUL  = 4'hD;
    localparam logic [3:0] OP_SWAP = 4'hE;
    localparam logic [3:0] OP_LOAD = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2
    } state_t;

    // Request snapshot taken at the accept edge; operands are read here so
    // later register writes cannot disturb an in-flight op.
    typedef struct packed {
        logic [3:0]       opcode;
        logic [AW-1:0]    src_a;
        logic [AW-1:0]    src_b;
        logic [AW-1:0]    dst;
        logic [WIDTH-1:0] din;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } req_t;

    state_t                     state_q, state_d;
    req_t                       req_q, req_d;
    logic [NREG-1:0][WIDTH-1:0] regs_q, regs_d;
    logic [WIDTH-1:0]           y_q, y_d;
    logic [3:0]                 flags_q, flags_d;
    logic                       rv_q, rv_d;
    logic [2*WIDTH-1:0]         acc_q, acc_d;
    logic [2*WIDTH-1:0]         mcand_q, mcand_d;
    logic [WIDTH-1:0]           mplr_q, mplr_d;
    logic [CW-1:0]              cnt_q, cnt_d;

    logic [WIDTH-1:0]           alu_r;
    logic                       alu_c;
    logic                       alu_v;
    logic [WIDTH:0]             sum_w;
    logic [2*WIDTH-1:0]         mul_next;

    assign op_ready  = (state_q == S_IDLE);
    assign Y         = y_q;
    assign flags     = flags_q;
    assign res_valid = rv_q;
    assign dbg_data  = regs_q[dbg_sel];

    // Single-cycle ALU on the snapshotted operands; C/V default to 0.
    always_comb begin
        alu_r = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        sum_w = '0;
        unique case (req_q.opcode)
            OP_ADD: begin
                sum_w = {1'b0, req_q.a} + {1'b0, req_q.b};
                alu_r = sum_w[WIDTH-1:0];
                alu_c = sum_w[WIDTH];
                alu_v = (req_q.a[WIDTH-1] == req_q.b[WIDTH-1]) &&
                        (alu_r[WIDTH-1] != req_q.a[WIDTH-1]);
            end
            OP_SUB: begin
                // Top bit of the widened difference is the unsigned borrow.
                sum_w = {1'b0, req_q.a} - {1'b0, req_q.b};
                alu_r = sum_w[WIDTH-1:0];
                alu_c = sum_w[WIDTH];
                alu_v = (req_q.a[WIDTH-1] != req_q.b[WIDTH-1]) &&
                        (alu_r[WIDTH-1] != req_q.a[WIDTH-1]);
            end
            OP_SHL: begin
                alu_r = {req_q.a[WIDTH-2:0], 1'b0};
                alu_c = req_q.a[WIDTH-1];
            end
            OP_SHR: begin
                alu_r = {1'b0, req_q.a[WIDTH-1:1]};
                alu_c = req_q.a[0];
            end
            OP_CMP: begin
                if (req_q.a == req_q.b)
                    alu_r = '0;
                else if ($signed(req_q.a) > $signed(req_q.b))
                    alu_r = WIDTH'(1);
                else
                    alu_r = '1;
            end
            OP_AND:  alu_r = req_q.a & req_q.b;
            OP_OR:   alu_r = req_q.a | req_q.b;
            OP_XOR:  alu_r = req_q.a ^ req_q.b;
            OP_NAND: alu_r = ~(req_q.a & req_q.b);
            OP_NOR:  alu_r = ~(req_q.a | req_q.b);
            OP_XNOR: alu_r = ~(req_q.a ^ req_q.b);
            OP_NOT:  alu_r = ~req_q.a;
            OP_NEG:  alu_r = -req_q.a;
            default: alu_r = '0;
        endcase
    end

    // Next-state: accept, single-cycle completion, and shift-add multiply.
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        regs_d   = regs_q;
        y_d      = y_q;
        flags_d  = flags_q;
        rv_d     = 1'b0;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplr_d   = mplr_q;
        cnt_d    = cnt_q;
        mul_next = acc_q + (mplr_q[0] ? mcand_q : '0);

        unique case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    req_d.opcode = opcode;
                    req_d.src_a  = src_a;
                    req_d.src_b  = src_b;
                    req_d.dst    = dst;
                    req_d.din    = data_in;
                    req_d.a      = regs_q[src_a];
                    req_d.b      = regs_q[src_b];
                    acc_d        = '0;
                    mcand_d      = {{WIDTH{1'b0}}, regs_q[src_a]};
                    mplr_d       = regs_q[src_b];
                    cnt_d        = '0;
                    state_d      = (opcode == OP_MUL) ? S_MUL : S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_IDLE;
                rv_d    = 1'b1;
                if (req_q.opcode == OP_SWAP) begin
                    // Equal indices write the same value twice: no change.
                    regs_d[req_q.src_a] = req_q.b;
                    regs_d[req_q.src_b] = req_q.a;
                end else if (req_q.opcode == OP_LOAD) begin
                    regs_d[req_q.dst] = req_q.din;
                end else begin
                    regs_d[req_q.dst] = alu_r;
                    y_d               = alu_r;
                    flags_d           = {alu_c, alu_v, alu_r[WIDTH-1], (alu_r == '0)};
                end
            end
            S_MUL: begin
                // One multiplier bit per cycle; the last bit folds straight
                // into the write so completion lands WIDTH edges after accept.
                acc_d   = mul_next;
                mcand_d = mcand_q << 1;
                mplr_d  = mplr_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d           = S_IDLE;
                    rv_d              = 1'b1;
                    regs_d[req_q.dst] = mul_next[WIDTH-1:0];
                    y_d               = mul_next[WIDTH-1:0];
                    flags_d           = {(|mul_next[2*WIDTH-1:WIDTH]), 1'b0,
                                         mul_next[WIDTH-1],
                                         (mul_next[WIDTH-1:0] == '0)};
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset discards any in-flight op.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            req_q   <= '0;
            regs_q  <= '0;
            y_q     <= '0;
            flags_q <= '0;
            rv_q    <= 1'b0;
            acc_q   <= '0;
            mcand_q <= '0;
            mplr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            regs_q  <= regs_d;
            y_q     <= y_d;
            flags_q <= flags_d;
            rv_q    <= rv_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_alu_regfile.sv
// Bench for alu_regfile (WIDTH=8, NREG=4): directed vectors plus random ops,
// scored against an arithmetic reference model through an expectation queue.
module tb_alu_regfile;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int AW = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          op_valid = 1'b0;
    logic          op_ready;
    logic [3:0]    opcode = '0;
    logic [AW-1:0] src_a = '0, src_b = '0, dst = '0, dbg_sel = '0;
    logic [W-1:0]  data_in = '0;
    logic [W-1:0]  Y;
    logic [W-1:0]  dbg_data;
    logic [3:0]    flags;
    logic          res_valid;

    alu_regfile #(.WIDTH(W), .NREG(N)) dut (
        .clock(clock), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
        .opcode(opcode), .src_a(src_a), .src_b(src_b), .dst(dst),
        .data_in(data_in), .Y(Y), .flags(flags), .res_valid(res_valid),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    always #10 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int y;
        int fl;
        int cyc;
    } exp_t;
    exp_t sbq[$];

    int mregs[N];
    int my  = 0;
    int mfl = 0;

    task automatic chk(input string name, input logic [31:0] got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic int sgn(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    // Reference model: plain integer arithmetic on the architectural state.
    task automatic model(input int op, input int sa, input int sb, input int d, input int din);
        int a, b, r, c, v, p, sv, t;
        a = mregs[sa];
        b = mregs[sb];
        r = 0; c = 0; v = 0;
        if (op == 14) begin
            t = mregs[sa];
            mregs[sa] = mregs[sb];
            mregs[sb] = t;
        end else if (op == 15) begin
            mregs[d] = din;
        end else begin
            case (op)
                0: begin
                    p = a + b; r = p & 255; c = (p > 255) ? 1 : 0;
                    sv = sgn(a) + sgn(b); v = (sv > 127 || sv < -128) ? 1 : 0;
                end
                1: begin
                    r = (a - b) & 255; c = (a < b) ? 1 : 0;
                    sv = sgn(a) - sgn(b); v = (sv > 127 || sv < -128) ? 1 : 0;
                end
                2: begin r = (a * 2) & 255; c = (a >= 128) ? 1 : 0; end
                3: begin r = a / 2; c = a % 2; end
                4: r = (sgn(a) == sgn(b)) ? 0 : (sgn(a) > sgn(b)) ? 1 : 255;
                5: r = a & b;
                6: r = a | b;
                7: r = a ^ b;
                8: r = ~(a & b) & 255;
                9: r = ~(a | b) & 255;
                10: r = ~(a ^ b) & 255;
                11: r = ~a & 255;
                12: r = (0 - a) & 255;
                13: begin p = a * b; r = p & 255; c = (p > 255) ? 1 : 0; end
                default: r = 0;
            endcase
            mregs[d] = r;
            my  = r;
            mfl = c * 8 + v * 4 + ((r >= 128) ? 2 : 0) + ((r == 0) ? 1 : 0);
        end
    endtask

    // Drive one request (caller is at a negedge with op_ready high).
    task automatic do_op(input int op, input int sa, input int sb, input int d, input int din);
        exp_t e;
        opcode   = op[3:0];
        src_a    = sa[AW-1:0];
        src_b    = sb[AW-1:0];
        dst      = d[AW-1:0];
        data_in  = din[W-1:0];
        op_valid = 1'b1;
        @(posedge clock);
        #1;
        op_valid = 1'b0;
        model(op, sa, sb, d, din);
        e.y   = my;
        e.fl  = mfl;
        e.cyc = cyc + ((op == 13) ? W : 1);
        sbq.push_back(e);
    endtask

    // Wait for op_ready at a negedge; optionally hold a LOAD request while busy.
    task automatic wait_idle(input bit hold, input int exp_n, input string name);
        int n;
        n = 0;
        if (hold) begin
            opcode = 4'hF; dst = 2'd3; data_in = 8'hEE; op_valid = 1'b1;
        end
        while (1) begin
            @(negedge clock);
            n++;
            if (op_ready === 1'b1 || n >= 60) break;
        end
        op_valid = 1'b0;
        chk(name, n, exp_n);
    endtask

    task automatic sweep(input string name);
        for (int s = 0; s < N; s++) begin
            dbg_sel = s[AW-1:0];
            #1;
            chk(name, dbg_data, mregs[s]);
        end
    endtask

    task automatic op_wait(input int op, input int sa, input int sb, input int d, input int din);
        do_op(op, sa, sb, d, din);
        wait_idle(1'b0, (op == 13) ? W + 1 : 2, "ready_latency");
    endtask

    // Monitor: every completion pulse must match the oldest expectation.
    always @(negedge clock) begin
        if (reset === 1'b1 && res_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("unexpected_res_valid", 32'd1, 0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("sb_y", Y, e.y);
                chk("sb_flags", flags, e.fl);
                chk("sb_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < N; i++) mregs[i] = 0;

        // Reset state
        #25;
        chk("rst_y", Y, 0);
        chk("rst_flags", flags, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_op_ready", op_ready, 1);
        sweep("rst_dbg");
        @(negedge clock);
        reset = 1'b1;

        // ADD overflow
        op_wait(15, 0, 0, 0, 'h7F);
        op_wait(15, 0, 0, 1, 'h01);
        op_wait(0, 0, 1, 2, 0);
        chk("add_y", Y, 'h80);
        chk("add_flags", flags, 'b0110);
        sweep("add_dbg");

        // SUB borrow
        op_wait(15, 0, 0, 0, 'h01);
        op_wait(15, 0, 0, 1, 'h02);
        op_wait(1, 0, 1, 2, 0);
        chk("sub_y", Y, 'hFF);
        chk("sub_flags", flags, 'b1010);

        // Signed CMP
        op_wait(15, 0, 0, 0, 'h80);
        op_wait(15, 0, 0, 1, 'h01);
        op_wait(4, 0, 1, 3, 0);
        chk("cmp_lt_y", Y, 'hFF);
        op_wait(15, 0, 0, 0, 'h33);
        op_wait(15, 0, 0, 1, 'h33);
        op_wait(4, 0, 1, 3, 0);
        chk("cmp_eq_y", Y, 'h00);
        chk("cmp_eq_flags", flags, 'b0001);

        // SWAP, including same-index swap
        op_wait(15, 0, 0, 0, 'hAA);
        op_wait(15, 0, 0, 1, 'h55);
        op_wait(14, 0, 1, 0, 0);
        dbg_sel = 2'd0; #1; chk("swap_r0", dbg_data, 'h55);
        dbg_sel = 2'd1; #1; chk("swap_r1", dbg_data, 'hAA);
        chk("swap_y_kept", Y, 'h00);
        op_wait(14, 2, 2, 0, 0);
        sweep("swap_same_dbg");

        // MUL with a request held while busy
        op_wait(15, 0, 0, 0, 'h10);
        op_wait(15, 0, 0, 1, 'h11);
        do_op(13, 0, 1, 2, 0);
        chk("mul_busy_ready", op_ready, 0);
        wait_idle(1'b1, W + 1, "mul_latency");
        chk("mul_y", Y, 'h10);
        chk("mul_flags", flags, 'b1000);
        sweep("mul_dbg");

        // Random ops against the model
        for (int i = 0; i < 80; i++) begin
            int op;
            op = $urandom_range(0, 15);
            op_wait(op, $urandom_range(0, N - 1), $urandom_range(0, N - 1),
                    $urandom_range(0, N - 1), $urandom_range(0, 255));
            sweep("rand_dbg");
        end

        // Reset in the middle of a MUL
        op_wait(15, 0, 0, 0, 'h5A);
        op_wait(15, 0, 0, 1, 'h07);
        do_op(13, 0, 1, 2, 0);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        sbq.delete();
        for (int i = 0; i < N; i++) mregs[i] = 0;
        my = 0; mfl = 0;
        #1;
        chk("midrst_y", Y, 0);
        chk("midrst_flags", flags, 0);
        chk("midrst_op_ready", op_ready, 1);
        sweep("midrst_dbg");
        repeat (10) @(negedge clock);
        chk("midrst_res_valid", res_valid, 0);
        reset = 1'b1;
        repeat (10) @(negedge clock);
        chk("postrst_no_pulse", res_valid, 0);
        sweep("postrst_dbg");
        op_wait(15, 0, 0, 0, 'h03);
        op_wait(15, 0, 0, 1, 'h04);
        op_wait(0, 0, 1, 2, 0);
        chk("postrst_add_y", Y, 'h07);
        chk("postrst_add_flags", flags, 0);

        repeat (3) @(negedge clock);
        chk("sb_drained", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
